count_cmp_sequencer: RTL

COUNT_CMP_SEQUENCER -- requirements
Module: count_cmp_sequencer

---
 rtl/count_cmp_sequencer.sv | 72 +++++++
 1 files changed

// File: rtl/count_cmp_sequencer.sv
// count_cmp_sequencer: sequences clear/count/drain runs on a counter-compare datapath and compacts its responses into a MISR signature.
module count_cmp_sequencer (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [8:0]  MASK,
  input  logic [7:0]  RUN_LEN,
  input  logic        W_IN,
  input  logic        Z_IN,
  output logic        X_OUT,
  output logic        CLEAR_OUT,
  output logic [8:0]  C_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SIG,
  output logic [7:0]  WCNT
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, FIN} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d, wcnt_d;
  logic [8:0] c_d;
  logic [15:0] sig_d;
  logic cap;
  assign cap = state == RUN || state == DRAIN;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    c_d = C_OUT;
    sig_d = cap ? {SIG[14:0], 1'b0} ^ (SIG[15] ? 16'h1021 : 16'h0000) ^ {14'b0, W_IN, Z_IN} : SIG;
    wcnt_d = cap && W_IN && WCNT != 8'hFF ? WCNT + 8'd1 : WCNT;
    case (state)
      IDLE: if (START) begin
        state_d = CLR;
        c_d = MASK;
        cnt_d = RUN_LEN;
        sig_d = 16'h0000;
        wcnt_d = 8'h00;
      end
      CLR: state_d = cnt != 8'd0 ? RUN : DRAIN;
      RUN: begin
        cnt_d = cnt - 8'd1;
        state_d = cnt == 8'd1 ? DRAIN : RUN;
      end
      DRAIN: state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // Control outputs are registered by decoding the next state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt <= 8'd0;
      C_OUT <= 9'h000;
      SIG <= 16'h0000;
      WCNT <= 8'h00;
      X_OUT <= 1'b0;
      CLEAR_OUT <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      C_OUT <= c_d;
      SIG <= sig_d;
      WCNT <= wcnt_d;
      X_OUT <= state_d == RUN;
      CLEAR_OUT <= state_d == CLR;
      BUSY <= state_d != IDLE;
      DONE <= state_d == FIN;
    end
  end
endmodule
